video_pattern_gen: RTL and testbench

// - Video timing and test-pattern source for the HDMI path, running in the clk_pixel domain.
// - Generates the raster counters, hsync, vsync and de, plus a 24-bit RGB pixel selected by the 4-bit color input.
// - Feeds the TMDS encoder/serialiser stage downstream.
// - Exports color, cnt_h_next, cnt_v_next and rgb_next so the on-chip analyzer can probe them.

---
 rtl/video_pkg.sv | 41 ++++
 rtl/video_timing_counter.sv | 46 ++++
 rtl/video_pattern_gen.sv | 140 ++++++++++++++
 tb/tb_video_pattern_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants for the HDMI test-pattern source: default 720p timing,
// pattern select codes and the colour-bar palette.
package video_pkg;

  localparam int CNT_W = 12;

  // Default 1280x720 timing.
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;
  localparam int DEF_BAR_STEP = 4;

  // Width of the moving bar, pixels.
  localparam int MOVBAR_W = 16;

  // Pattern select codes; 9..15 fall back to the colour bars.
  localparam logic [3:0] PAT_BLACK   = 4'd0;
  localparam logic [3:0] PAT_WHITE   = 4'd1;
  localparam logic [3:0] PAT_RED     = 4'd2;
  localparam logic [3:0] PAT_GREEN   = 4'd3;
  localparam logic [3:0] PAT_BLUE    = 4'd4;
  localparam logic [3:0] PAT_BARS    = 4'd5;
  localparam logic [3:0] PAT_GRAY    = 4'd6;
  localparam logic [3:0] PAT_CHECKER = 4'd7;
  localparam logic [3:0] PAT_MOVBAR  = 4'd8;

  localparam logic [23:0] RGB_BLACK = 24'h000000;
  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;

  // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/video_timing_counter.sv
// Raster position counters for the pixel-clock domain, with their
// combinational next values and frame-boundary strobes.
module video_timing_counter
  import video_pkg::*;
#(
  parameter int H_TOTAL = 1650,
  parameter int V_TOTAL = 750
) (
  input  logic             clk_pixel,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt_h,
  output logic [CNT_W-1:0] cnt_v,
  output logic [CNT_W-1:0] cnt_h_next,
  output logic [CNT_W-1:0] cnt_v_next,
  output logic             frame_start,
  output logic             frame_next
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Next raster position: horizontal wraps every line, vertical steps on the wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cnt_h_next = (cnt_h == H_LAST) ? '0 : cnt_h + 1'b1;
    cnt_v_next = cnt_v;
    if (cnt_h == H_LAST) begin
      cnt_v_next = (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
    end
    frame_start = (cnt_h == '0) && (cnt_v == '0);
    frame_next  = (cnt_h_next == '0) && (cnt_v_next == '0);
  end

  // Position register; reset puts the raster at pixel (0,0).
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
      cnt_h <= cnt_h_next;
      cnt_v <= cnt_v_next;
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern source: decodes the raster position into
// sync/enable and a selectable RGB pattern, registered once for the encoder.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int BAR_STEP = DEF_BAR_STEP
) (
  input  logic             clk_pixel,
  input  logic             rst_n,
  input  logic [3:0]       color,
  output logic [CNT_W-1:0] cnt_h_next,
  output logic [CNT_W-1:0] cnt_v_next,
  output logic [23:0]      rgb_next,
  output logic [23:0]      rgb,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] HA_L     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VA_L     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] cnt_h;
  logic [CNT_W-1:0] cnt_v;
  logic             frame_start_cnt;
  logic             frame_next;

  logic [3:0]       pat_q;
  logic [CNT_W-1:0] bar_off;
  logic [CNT_W-1:0] bar_off_next;
  logic [CNT_W:0]   off_sum;
  logic [CNT_W:0]   mov_end;
  logic             in_bar;
  logic [2:0]       bar_idx;
  logic             de_next;
  logic             hs_next;
  logic             vs_next;

  video_timing_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_timing (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .cnt_h       (cnt_h),
    .cnt_v       (cnt_v),
    .cnt_h_next  (cnt_h_next),
    .cnt_v_next  (cnt_v_next),
    .frame_start (frame_start_cnt),
    .frame_next  (frame_next)
  );

  // Moving-bar offset for the next frame, wrapped modulo the active width.
  always_comb begin
    off_sum      = {1'b0, bar_off} + (CNT_W+1)'(BAR_STEP);
    bar_off_next = off_sum[CNT_W-1:0];
    if (off_sum >= (CNT_W+1)'(H_ACTIVE)) begin
      bar_off_next = CNT_W'(off_sum - (CNT_W+1)'(H_ACTIVE));
    end
  end

  // Per-frame state: pattern select and bar offset both change only at the frame boundary.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= PAT_BLACK;
      bar_off <= '0;
    end else if (frame_next) begin
      pat_q   <= color;
      bar_off <= bar_off_next;
    end
  end

  // Position decode: sync/enable windows and the pixel colour for the current position.
  always_comb begin
    de_next = (cnt_h < HA_L) && (cnt_v < VA_L);
    hs_next = ((cnt_h >= HS_START) && (cnt_h < HS_END)) ? HS_POL : !HS_POL;
    vs_next = ((cnt_v >= VS_START) && (cnt_v < VS_END)) ? VS_POL : !VS_POL;

    // Colour-bar index from constant edges; the lowest edge above cnt_h wins.
    bar_idx = 3'd7;
    for (int i = 7; i >= 1; i--) begin
      if (int'(cnt_h) < i * BAR_W) bar_idx = 3'(i - 1);
    end

    // Bar may extend past the active width; de clips it at the right edge.
    mov_end = {1'b0, bar_off} + (CNT_W+1)'(MOVBAR_W);
    in_bar  = (cnt_h >= bar_off) && ({1'b0, cnt_h} < mov_end);

    case (pat_q)
      PAT_BLACK:   rgb_next = RGB_BLACK;
      PAT_WHITE:   rgb_next = RGB_WHITE;
      PAT_RED:     rgb_next = 24'hFF0000;
      PAT_GREEN:   rgb_next = 24'h00FF00;
      PAT_BLUE:    rgb_next = 24'h0000FF;
      PAT_GRAY:    rgb_next = {3{cnt_h[7:0]}};
      PAT_CHECKER: rgb_next = (cnt_h[5] ^ cnt_v[5]) ? RGB_WHITE : RGB_BLACK;
      PAT_MOVBAR:  rgb_next = in_bar ? RGB_WHITE : RGB_BLACK;
      default:     rgb_next = BAR_RGB[bar_idx];
    endcase

    if (!de_next) rgb_next = RGB_BLACK;
  end

  // Output register: one stage, all video outputs aligned to the same position.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      rgb         <= '0;
      de          <= 1'b0;
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      frame_start <= 1'b0;
    end else begin
      rgb         <= rgb_next;
      de          <= de_next;
      hsync       <= hs_next;
      vsync       <= vs_next;
      frame_start <= frame_start_cnt;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen on a reduced raster so several
// whole frames fit in a short run; expected pixels come from a position model.
module tb_video_pattern_gen;

  localparam int HA = 64, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 36, VFP = 2, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;   // 80
  localparam int VT = VA + VFP + VSW + VBP;   // 42
  localparam int FRAME = HT * VT;             // 3360
  localparam int STEP = 4;
  localparam bit HS_POL = 1'b1, VS_POL = 1'b1;

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  color = 4'd0;
  logic [11:0] cnt_h_next, cnt_v_next;
  logic [23:0] rgb_next, rgb;
  logic        de, hsync, vsync, frame_start;

  int checks = 0;
  int failures = 0;
  int k;                  // rising edges since the last reset release
  int act_cnt;
  int pat_frame [0:31];   // pattern in effect for each frame since release
  int sched [0:31];       // colour presented for latching at the end of frame f-1

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .BAR_STEP(STEP)
  ) u_dut (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .color       (color),
    .cnt_h_next  (cnt_h_next),
    .cnt_v_next  (cnt_v_next),
    .rgb_next    (rgb_next),
    .rgb         (rgb),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference pixel colour for an active position.
  function automatic logic [23:0] ref_rgb(input int x, input int y, input int pat, input int off);
    logic [7:0] g;
    g = 8'(x % 256);
    case (pat)
      0: return 24'h000000;
      1: return 24'hFFFFFF;
      2: return 24'hFF0000;
      3: return 24'h00FF00;
      4: return 24'h0000FF;
      6: return {g, g, g};
      7: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      8: return (x >= off && x < off + 16) ? 24'hFFFFFF : 24'h000000;
      default: return bar_tab[x / (HA / 8)];
    endcase
  endfunction

  task automatic sample_and_check(input int run_id);
    int x, y, f, off, x2, y2;
    logic e_de, e_hs, e_vs, e_fs;
    logic [23:0] e_rgb;
    int bx [5] = '{0, 7, 8, 55, 56};
    logic [23:0] bc [5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h0000FF, 24'h000000};
    x = k % HT; y = (k / HT) % VT; f = k / FRAME;
    off = (f * STEP) % HA;
    e_de = (x < HA) && (y < VA);
    e_hs = (x >= HA + HFP && x < HA + HFP + HSW) ? HS_POL : !HS_POL;
    e_vs = (y >= VA + VFP && y < VA + VFP + VSW) ? VS_POL : !VS_POL;
    e_fs = (x == 0) && (y == 0);
    e_rgb = e_de ? ref_rgb(x, y, pat_frame[f], off) : 24'h0;
    check($sformatf("px r%0d f%0d x%0d y%0d", run_id, f, x, y),
          64'({de, hsync, vsync, frame_start, rgb}), 64'({e_de, e_hs, e_vs, e_fs, e_rgb}));
    x2 = (k + 2) % HT; y2 = ((k + 2) / HT) % VT;
    check($sformatf("cnt_next k%0d", k), 64'({cnt_v_next, cnt_h_next}), 64'({12'(y2), 12'(x2)}));

    if (k == 0) begin
      check("first_de", 64'(de), 64'(1));
      check("first_frame_start", 64'(frame_start), 64'(1));
      check("first_pixel_black", 64'(rgb), 64'(0));
    end
    if (k == HA + HFP - 1) check("hsync_before", 64'(hsync), 64'(!HS_POL));
    if (k == HA + HFP)     check("hsync_first", 64'(hsync), 64'(HS_POL));
    if (run_id == 0) begin
      if (f == 1 && de) act_cnt++;
      if (k == 2 * FRAME - 1) check("active_count", 64'(act_cnt), 64'(HA * VA));
      if (f == 2 && y == 0)
        for (int i = 0; i < 5; i++)
          if (x == bx[i]) check($sformatf("bars x%0d", x), 64'(rgb), 64'(bc[i]));
      if (f == 3 && x == HA - 1 && y == VA - 1) check("frameN_last_white", 64'(rgb), 64'(24'hFFFFFF));
      if (f == 4 && x == 0 && y == 0) check("frameN1_first_green", 64'(rgb), 64'(24'h00FF00));
      if (f >= 7 && f <= 17 && y == 0) begin
        if (x == off) check($sformatf("movbar edge f%0d", f), 64'(rgb), 64'(24'hFFFFFF));
        if (off > 0 && x == off - 1) check($sformatf("movbar left f%0d", f), 64'(rgb), 64'(0));
      end
      if (f == 15 && y == 0 && x == HA - 1) check("movbar_clip_right", 64'(rgb), 64'(24'hFFFFFF));
      if (f == 16 && y == 0 && x == 16) check("movbar_wrap_end", 64'(rgb), 64'(0));
    end else begin
      if (f == 1 && x == 0 && y == 0) check("restart_blue", 64'(rgb), 64'(24'h0000FF));
    end
  endtask

  task automatic run_cycles(input int n, input int run_id);
    int m;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pixel);
      if (k % FRAME == FRAME - 1) pat_frame[k / FRAME + 1] = int'(color);
      #1;
      sample_and_check(run_id);
      m = k % FRAME;
      if (m == FRAME - 10) color = 4'(sched[k / FRAME + 1]);
      else if (m < FRAME - 10 && $urandom_range(0, 99) < 2) color = 4'($urandom_range(0, 15));
      if (run_id == 0 && k / FRAME == 3 && m == (VA / 2) * HT) color = 4'd3;
      k++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) sched[i] = $urandom_range(0, 15);
    sched[1] = 2; sched[2] = 5; sched[3] = 1; sched[4] = 3; sched[5] = 6; sched[6] = 7;
    for (int i = 7; i <= 17; i++) sched[i] = 8;
    color = 4'($urandom_range(0, 15));
    rst_n = 1'b0;
    repeat (10) @(posedge clk_pixel);
    #1;
    check("rst_outputs", 64'({de, hsync, vsync, frame_start, rgb}),
          64'({1'b0, !HS_POL, !VS_POL, 1'b0, 24'h0}));
    check("rst_cnt_next", 64'({cnt_v_next, cnt_h_next}), 64'({12'd0, 12'd1}));

    @(negedge clk_pixel);
    rst_n = 1'b1;
    k = 0; act_cnt = 0; pat_frame[0] = 0;
    run_cycles(20 * FRAME, 0);
    color = 4'd1;
    run_cycles((VA / 2) * HT + HA / 2 + 1, 0);

    // Reset in the middle of the active area must clear the outputs without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 64'({de, hsync, vsync, frame_start, rgb}),
          64'({1'b0, !HS_POL, !VS_POL, 1'b0, 24'h0}));
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    rst_n = 1'b1;
    k = 0; pat_frame[0] = 0; sched[1] = 4;
    run_cycles(2 * FRAME, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
